// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Purpose  : Boot-time loader: frames a byte stream into words, writes them to
//            the instruction store from address 0 and checks an XOR checksum.
// Revision : 1.0  initial release
// ============================================================================
module program_loader #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     write_enable,
  output logic [ADDRESS_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0]    write_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int MAX_WORDS = ((2 ** ADDRESS_WIDTH) < 255) ? (2 ** ADDRESS_WIDTH) : 255;
  localparam int BC_W      = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BC_W-1:0] C_LAST_BYTE = BC_W'(BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LENGTH = 2'd1,
    ST_DATA   = 2'd2,
    ST_CHECK  = 2'd3
  } state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic [7:0]                 r_length;
  logic [7:0]                 r_word_count;
  logic [BC_W-1:0]            r_byte_count;
  logic [7:0]                 r_checksum;
  logic [DATA_WIDTH-1:0]      r_word;
  logic                       r_write_enable;
  logic [ADDRESS_WIDTH-1:0]   r_write_address;
  logic [DATA_WIDTH-1:0]      r_write_data;
  logic                       r_done;
  logic                       r_error;

  logic                       w_active;
  logic                       w_accept;
  logic                       w_len_ok;
  logic                       w_last_byte;
  logic                       w_last_word;
  logic [DATA_WIDTH-1:0]      w_shifted;

  // Handshake readiness is purely a state decode so upstream never sees a
  // combinational path from in_valid back to in_ready.
  assign w_active    = (r_state != ST_IDLE);
  assign w_accept    = in_valid && w_active;
  assign w_len_ok    = (in_data != 8'd0) && ({24'd0, in_data} <= 32'(MAX_WORDS));
  assign w_last_byte = (r_byte_count == C_LAST_BYTE);
  assign w_last_word = (r_word_count == (r_length - 8'd1));
  // Little-endian assembly: bytes enter at the top and drift down, so the
  // first byte of a word ends up in bits [7:0].
  assign w_shifted   = (r_word >> 8) | (DATA_WIDTH'(in_data) << (DATA_WIDTH - 8));

  assign in_ready      = w_active;
  assign busy          = w_active;
  assign write_enable  = r_write_enable;
  assign write_address = r_write_address;
  assign write_data    = r_write_data;
  assign done          = r_done;
  assign error         = r_error;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_LENGTH;
      end
      ST_LENGTH: begin
        if (w_accept) w_next = w_len_ok ? ST_DATA : ST_IDLE;
      end
      ST_DATA: begin
        if (w_accept && w_last_byte && w_last_word) w_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (w_accept) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_length        <= 8'd0;
      r_word_count    <= 8'd0;
      r_byte_count    <= '0;
      r_checksum      <= 8'd0;
      r_word          <= '0;
      r_write_enable  <= 1'b0;
      r_write_address <= '0;
      r_write_data    <= '0;
      r_done          <= 1'b0;
      r_error         <= 1'b0;
    end else begin
      r_write_enable <= 1'b0;
      r_done         <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_error      <= 1'b0;
            r_checksum   <= 8'd0;
            r_byte_count <= '0;
            r_word_count <= 8'd0;
          end
        end
        ST_LENGTH: begin
          if (w_accept) begin
            if (w_len_ok) begin
              r_length <= in_data;
            end else begin
              r_error <= 1'b1;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (w_accept) begin
            r_checksum <= r_checksum ^ in_data;
            r_word     <= w_shifted;
            if (w_last_byte) begin
              r_byte_count    <= '0;
              r_write_enable  <= 1'b1;
              r_write_data    <= w_shifted;
              r_write_address <= ADDRESS_WIDTH'(r_word_count);
              r_word_count    <= r_word_count + 8'd1;
            end else begin
              r_byte_count <= r_byte_count + 1'b1;
            end
          end
        end
        ST_CHECK: begin
          if (w_accept) begin
            r_done  <= 1'b1;
            r_error <= (in_data != r_checksum);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_loader
// Purpose  : Directed + randomized self-checking bench for program_loader.
// Revision : 1.0  initial release
// ============================================================================
module tb_program_loader;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int MAXW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    in_data = 8'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          write_enable;
  logic [AW-1:0] write_address;
  logic [DW-1:0] write_data;
  logic          busy;
  logic          done;
  logic          error;

  program_loader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .write_enable(write_enable),
    .write_address(write_address), .write_data(write_data), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference expectations derived from the frame contents alone.
  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];
  logic          exp_err;
  int            exp_nbytes;

  // Observations collected between clock edges.
  logic [AW-1:0] cap_addr[$];
  logic [DW-1:0] cap_data[$];
  int            done_count = 0;
  int            bad_ready = 0;

  always @(negedge clock) begin
    if (write_enable === 1'b1) begin
      cap_addr.push_back(write_address);
      cap_data.push_back(write_data);
    end
    if (done === 1'b1) done_count++;
    if (in_ready !== busy) bad_ready++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [7:0] f[$]);
    int L;
    logic [7:0] cs;
    logic [DW-1:0] word;
    exp_addr.delete();
    exp_data.delete();
    L = int'(f[0]);
    if (L == 0 || L > MAXW) begin
      exp_err = 1'b1;
      exp_nbytes = 1;
      return;
    end
    cs = 8'd0;
    for (int w = 0; w < L; w++) begin
      word = '0;
      for (int b = 0; b < DW / 8; b++) begin
        word = word + (DW'(f[1 + w * (DW / 8) + b]) << (8 * b));
        cs = cs ^ f[1 + w * (DW / 8) + b];
      end
      exp_addr.push_back(AW'(w));
      exp_data.push_back(word);
    end
    exp_err = (f[1 + L * (DW / 8)] != cs);
    exp_nbytes = 2 + L * (DW / 8);
  endtask

  task automatic build_frame(input int L, input bit incr, input bit good, output logic [7:0] f[$]);
    logic [7:0] cs;
    logic [DW-1:0] word;
    f.delete();
    f.push_back(8'(L));
    cs = 8'd0;
    for (int w = 0; w < L; w++) begin
      word = incr ? DW'(32'h0101_0100 * w + w + 1) : DW'($urandom);
      for (int b = 0; b < DW / 8; b++) begin
        f.push_back(word[8*b +: 8]);
        cs = cs ^ word[8*b +: 8];
      end
    end
    f.push_back(good ? cs : (cs ^ 8'(1 + $urandom_range(254))));
  endtask

  // Drives bytes, holding each until a transfer; returns at the negedge
  // following the final accepting edge.
  task automatic send_bytes(input logic [7:0] q[$], input int gap_pct, input bit noise);
    int idx = 0;
    int cyc = 0;
    while (idx < q.size() && cyc < 4000) begin
      @(negedge clock);
      in_data  = q[idx];
      in_valid = ($urandom_range(99) >= gap_pct);
      start    = noise ? 1'($urandom_range(1)) : 1'b0;
      if (in_valid && in_ready) idx++;
      cyc++;
    end
    @(negedge clock);
    in_valid = 1'b0;
    start    = 1'b0;
    if (cyc >= 4000) check("send_timeout", 64'd1, 64'd0);
  endtask

  task automatic run_load(input string tag, input logic [7:0] f[$], input int gap_pct, input bit noise);
    logic [7:0] q[$];
    int d0;
    model(f);
    cap_addr.delete();
    cap_data.delete();
    bad_ready = 0;
    d0 = done_count;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
    check({tag, "_ready_after_start"}, 64'(in_ready), 64'd1);
    q = f[0:exp_nbytes-1];
    send_bytes(q, gap_pct, noise);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_error"}, 64'(error), 64'(exp_err));
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
    check({tag, "_ready_end"}, 64'(in_ready), 64'd0);
    @(negedge clock);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_error_hold"}, 64'(error), 64'(exp_err));
    check({tag, "_done_count"}, 64'(done_count - d0), 64'd1);
    check({tag, "_ready_vs_busy"}, 64'(bad_ready), 64'd0);
    check({tag, "_nwrites"}, 64'(cap_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < cap_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(cap_addr[i]), 64'(exp_addr[i]));
      check($sformatf("%s_data%0d", tag, i), 64'(cap_data[i]), 64'(exp_data[i]));
    end
  endtask

  initial begin
    #20000000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] f[$];
    logic [7:0] q[$];
    int d0;

    // Reset state
    #12;
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_we", 64'(write_enable), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_addr", 64'(write_address), 64'd0);
    check("rst_data", 64'(write_data), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // Nominal frame; 0x2A is the XOR of its eight data bytes
    f = '{8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    run_load("nominal", f, 0, 1'b0);
    check("nominal_word0", 64'(exp_data[0]), 64'h1234_5678);
    check("nominal_word1", 64'(exp_data[1]), 64'hDEAD_BEEF);

    // Checksum mismatch, then a good load clears error
    f[9] = 8'h5A;
    run_load("badsum", f, 0, 1'b0);
    f[9] = 8'h2A;
    run_load("recover", f, 0, 1'b0);

    // Bad lengths
    f = '{8'h00};
    run_load("len0", f, 0, 1'b0);
    f = '{8'h11};
    run_load("len17", f, 0, 1'b0);
    f = '{8'hFF};
    run_load("len255", f, 0, 1'b0);

    // Full memory, incrementing words
    build_frame(MAXW, 1'b1, 1'b1, f);
    run_load("full", f, 0, 1'b0);

    // Gapped nominal with start noise while busy
    f = '{8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    run_load("gapped_nominal", f, 40, 1'b1);

    // Randomized frames, some with corrupt checksums
    for (int k = 0; k < 12; k++) begin
      build_frame($urandom_range(1, MAXW), 1'b0, 1'($urandom_range(1)), f);
      run_load($sformatf("rand%0d", k), f, $urandom_range(0, 60), 1'($urandom_range(1)));
    end

    // Reset after 5 data bytes of an L=2 load
    f = '{8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    cap_addr.delete();
    cap_data.delete();
    d0 = done_count;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    q = f[0:5];
    send_bytes(q, 0, 1'b0);
    #1 reset = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ready", 64'(in_ready), 64'd0);
    check("abort_we", 64'(write_enable), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_error", 64'(error), 64'd0);
    check("abort_addr", 64'(write_address), 64'd0);
    check("abort_data", 64'(write_data), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_nwrites", 64'(cap_addr.size()), 64'd1);
    if (cap_addr.size() > 0) begin
      check("abort_addr0", 64'(cap_addr[0]), 64'd0);
      check("abort_data0", 64'(cap_data[0]), 64'h1234_5678);
    end
    check("abort_no_done", 64'(done_count - d0), 64'd0);
    run_load("after_abort", f, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
